dmem_copy_ctrl: RTL
===================

// Module: dmem_copy_ctrl
// PURPOSE
//  Word-granular memmove sequencer that owns data-memory port 2 (a2/wd2/we2/rd2).
//  Port 1 stays with the pipeline MEM stage.
//  Accepts src/dst/length commands and copies by alternating read and write cycles on port 2.
//  Handles overlapping regions and retries writes lost to port-1 write priority.
//  Backs the memcpy extension of the RV32I core.
// PARAMETERS
//  DEPTH_WORDS  64  words in data memory; valid byte addresses are 0 .. 4*DEPTH_WORDS-1
//  LEN_W        7   width of len_words; must hold DEPTH_WORDS
// PORTS
//  clk         in   1      clock, rising edge
//  reset       in   1      asynchronous, active-high
//  start       in   1      command strobe; sampled only in IDLE
//  src_addr    in   32     source byte address
//  dst_addr    in   32     destination byte address
//  len_words   in   LEN_W  number of words to copy
//  abort       in   1      terminate the copy in progress
//  cpu_we1     in   1      port-1 write this cycle; a port-2 write in the same cycle is lost
//  mem_rd2     in   32     port-2 read data (combinational from mem_a2)
//  mem_a2      out  32     port-2 byte address
//  mem_wd2     out  32     port-2 write data
//  mem_we2     out  1      port-2 write enable
//  busy        out  1      high in RD and WR states
//  done        out  1      one-cycle completion pulse
//  err         out  1      one-cycle pulse, coincident with done, on reject or abort
//  words_left  out  LEN_W  words remaining to copy
// BEHAVIOUR
//  Reset: state=IDLE; mem_a2, mem_wd2, mem_we2, busy, done, err, words_left all 0.
//   Reset is immediate and asynchronous, including mid-copy.
//   Words already written to dst are left as written.
//  States: IDLE -> RD <-> WR -> DONE -> IDLE.
//  IDLE, start=1: check the command (range checker below).
//   - Reject -> DONE with err. No memory access.
//   - len_words=0 -> DONE with err=0. No memory access.
//   - Otherwise latch cnt=len_words and pick the direction, then go to RD.
//  Reject conditions:
//   - src_addr[1:0] or dst_addr[1:0] nonzero.
//   - src_addr[31:2]+len_words > DEPTH_WORDS.
//   - dst_addr[31:2]+len_words > DEPTH_WORDS.
//   The sums use LEN_W+31-bit arithmetic, so they cannot wrap.
//  Direction:
//   - Descending when dst>src and dst<src+4*len. Pointers start at base+4*(len-1) and step -4.
//   - Ascending otherwise. Pointers start at base and step +4.
//  RD: mem_a2=src_ptr, mem_we2=0. At the edge, buf<=mem_rd2 and go to WR.
//  WR: mem_a2=dst_ptr, mem_wd2=buf, mem_we2=1.
//   - cpu_we1=1 at the edge: the write was lost. Stay in WR; same address and data next cycle.
//   - Otherwise: cnt-=1, src_ptr and dst_ptr step. Go to DONE if cnt becomes 0, else RD.
//  abort=1 in RD or WR: go to DONE with err=1.
//   A write presented in the abort cycle still commits at that edge.
//   It is not counted in words_left.
//  DONE: done=1 for one cycle (err as latched), busy=0. Next cycle -> IDLE.
//  start outside IDLE is ignored; no queueing.
//  Latency, no port-1 conflicts:
//   - start edge at cycle 0 -> busy high in cycles 1..2N.
//   - done in cycle 2N+1.
//   - Each lost write adds 1 cycle.
//  Combinational outputs: mem_a2, mem_wd2 and mem_we2 derive only from registered state.
//   No path from inputs to these outputs.
//  words_left = cnt; it is 0 in IDLE.
//  Coherency of CPU stores into the src/dst ranges during a copy is software's responsibility.
// STRUCTURE
//  Package dmem_copy_pkg:
//   - typedef enum logic [1:0] {IDLE, RD, WR, DONE} copy_state_t
//   - localparam WORD_BYTES=4
//  Sub-module copy_range_chk (combinational): src, dst, len -> reject, descending.
//  Single always_ff for state, pointers, cnt and buf. always_comb for port-2 drive.
// TESTING
//  1. RAM[0..3]=A,B,C,D; src=0x00, dst=0x40, len=4
//     -> RAM[16..19]=A..D; busy 8 cycles; done in cycle 9; err=0.
//  2. RAM[0..2]=1,2,3; src=0x00, dst=0x04, len=3
//     -> writes to 0x0C, 0x08, 0x04 in that order; RAM[1..3]=1,2,3; RAM[0]=1.
//  3. Scenario 1 with cpu_we1=1 during the first WR
//     -> WR repeats with mem_a2=0x40, mem_wd2=A; done in cycle 10.
//  4. src=0x02, or dst=0xF8 with len=4
//     -> done=err=1 in cycle 1; mem_we2 never asserted.
//  5. len=0 -> done=1, err=0 in cycle 1; no writes.
//  6. abort during the WR of word 3 of 4, then a separate copy with reset mid-copy:
//     - abort -> word 3 written; done=err=1 next cycle; words_left=2 during DONE.
//     - reset mid-copy -> all outputs 0 in the same cycle.

Source files
------------

// File: rtl/dmem_copy_pkg.sv
// Shared types and constants for the data-memory copy sequencer.
package dmem_copy_pkg;

  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} copy_state_t;

endpackage

// File: rtl/copy_range_chk.sv
// Command screening for the copy sequencer: bounds/alignment reject and copy direction.
module copy_range_chk
  import dmem_copy_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned LEN_W       = 7
) (
  input  logic [31:0]      src,
  input  logic [31:0]      dst,
  input  logic [LEN_W-1:0] len,
  output logic             reject,
  output logic             descending
);

  localparam int unsigned SUM_W  = LEN_W + 31;
  localparam int unsigned SPAN_W = LEN_W + 33;

  logic [SUM_W-1:0]  src_end;
  logic [SUM_W-1:0]  dst_end;
  logic [SPAN_W-1:0] src_lim;

  // Sums are wide enough that an oversized command can never wrap back into range.
  always_comb begin
    src_end    = SUM_W'(src[31:2]) + SUM_W'(len);
    dst_end    = SUM_W'(dst[31:2]) + SUM_W'(len);
    src_lim    = SPAN_W'(src) + SPAN_W'(len) * SPAN_W'(WORD_BYTES);
    reject     = (src[1:0] != 2'b00) || (dst[1:0] != 2'b00) ||
                 (src_end > SUM_W'(DEPTH_WORDS)) || (dst_end > SUM_W'(DEPTH_WORDS));
    descending = (dst > src) && (SPAN_W'(dst) < src_lim);
  end

endmodule

// File: rtl/dmem_copy_ctrl.sv
// Word-granular memmove sequencer driving data-memory port 2 with alternating read/write cycles.
module dmem_copy_ctrl
  import dmem_copy_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned LEN_W       = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len_words,
  input  logic             abort,
  input  logic             cpu_we1,
  input  logic [31:0]      mem_rd2,
  output logic [31:0]      mem_a2,
  output logic [31:0]      mem_wd2,
  output logic             mem_we2,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [LEN_W-1:0] words_left
);

  copy_state_t      state;
  copy_state_t      state_nx;
  logic             err_nx;
  logic             accept;
  logic             reject;
  logic             descending;
  logic             desc_q;
  logic [31:0]      src_ptr;
  logic [31:0]      dst_ptr;
  logic [31:0]      data_buf;
  logic [31:0]      step;
  logic [31:0]      first_off;
  logic [LEN_W-1:0] cnt;

  copy_range_chk #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .LEN_W       (LEN_W)
  ) u_range_chk (
    .src        (src_addr),
    .dst        (dst_addr),
    .len        (len_words),
    .reject     (reject),
    .descending (descending)
  );

  assign accept     = start && !reject && (len_words != '0);
  assign first_off  = (32'(len_words) - 32'd1) * 32'(WORD_BYTES);
  assign step       = desc_q ? (32'd0 - 32'(WORD_BYTES)) : 32'(WORD_BYTES);
  assign words_left = cnt;

  // Next-state and error decision.
  always_comb begin
    state_nx = state;
    err_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (reject) begin
            state_nx = DONE;
            err_nx   = 1'b1;
          end else if (len_words == '0) begin
            state_nx = DONE;
          end else begin
            state_nx = RD;
          end
        end
      end
      RD: begin
        if (abort) begin
          state_nx = DONE;
          err_nx   = 1'b1;
        end else begin
          state_nx = WR;
        end
      end
      WR: begin
        if (abort) begin
          state_nx = DONE;
          err_nx   = 1'b1;
        end else if (!cpu_we1) begin
          state_nx = (cnt == LEN_W'(1)) ? DONE : RD;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // A write lost to port 1 leaves pointers and count untouched so WR simply repeats.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      desc_q   <= 1'b0;
      src_ptr  <= '0;
      dst_ptr  <= '0;
      data_buf <= '0;
      cnt      <= '0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx == RD) || (state_nx == WR);
      done  <= (state_nx == DONE);
      err   <= err_nx;
      case (state)
        IDLE: begin
          if (accept) begin
            cnt     <= len_words;
            desc_q  <= descending;
            src_ptr <= descending ? (src_addr + first_off) : src_addr;
            dst_ptr <= descending ? (dst_addr + first_off) : dst_addr;
          end
        end
        RD: data_buf <= mem_rd2;
        WR: begin
          if (!abort && !cpu_we1) begin
            cnt     <= cnt - LEN_W'(1);
            src_ptr <= src_ptr + step;
            dst_ptr <= dst_ptr + step;
          end
        end
        DONE:    cnt <= '0;
        default: cnt <= '0;
      endcase
    end
  end

  // Port-2 drive from registered state only.
  always_comb begin
    mem_a2  = '0;
    mem_wd2 = '0;
    mem_we2 = 1'b0;
    case (state)
      RD: mem_a2 = src_ptr;
      WR: begin
        mem_a2  = dst_ptr;
        mem_wd2 = data_buf;
        mem_we2 = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
